// File: rtl/agrupate_cfg_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | agrupate_cfg_if : beat input / group output stream bundle. Rev 1.0        |
// +--------------------------------------------------------------------------+
interface agrupate_cfg_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_GROUP_SIZE = 4
);
  localparam int c_IN_W  = DATA_WIDTH + MAX_GROUP_SIZE * MAX_GROUP_SIZE + MAX_GROUP_SIZE;
  localparam int c_OUT_W = MAX_GROUP_SIZE * DATA_WIDTH;

  logic [c_IN_W-1:0]  data_in;
  logic               valid_in;
  logic               avail_out;
  logic [c_OUT_W-1:0] data_out;
  logic               valid_out;
  logic               avail_in;

  modport slave (
    input  data_in, valid_in, avail_in,
    output avail_out, data_out, valid_out
  );

  modport master (
    output data_in, valid_in, avail_in,
    input  avail_out, data_out, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/agrupate_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | agrupate_cfg : rebuilds output groups from unique results + FIFO buffer.  |
// | Optional macro AGRUPATE_CFG_STATS_EN adds stat_* counters.   Rev 1.0      |
// +--------------------------------------------------------------------------+
module agrupate_cfg #(
  parameter int DATA_WIDTH             = 16,
  parameter int MAX_GROUP_SIZE         = 4,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int OUT_FIFO_DEPTH         = 4
) (
  input  wire logic                                clk,
  input  wire logic                                rst,
  input  wire logic                                configure,
  input  wire logic [LOG_MAX_ITERS-1:0]            num_iters,
  input  wire logic [LOG_MAX_READS_PER_ITER-1:0]   num_reads_per_iter,
  input  wire logic [$clog2(MAX_GROUP_SIZE+1)-1:0] cfg_group_size,
  agrupate_cfg_if.slave                            bus,
  output logic                                     done
`ifdef AGRUPATE_CFG_STATS_EN
  ,
  output logic [31:0]                              stat_groups,
  output logic [31:0]                              stat_zero_slots
`endif
);
  localparam int c_G        = MAX_GROUP_SIZE;
  localparam int c_SW       = $clog2(MAX_GROUP_SIZE + 1);
  localparam int c_AW       = $clog2(OUT_FIFO_DEPTH);
  localparam int c_CW       = c_AW + 1;
  localparam int c_OW       = c_G * DATA_WIDTH;
  localparam int c_REP_LSB  = DATA_WIDTH;
  localparam int c_ZERO_LSB = DATA_WIDTH + c_G * c_G;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [c_SW-1:0]                  r_size, w_size_cfg;
  logic [31:0]                      r_total, w_total_cfg, r_group_cnt, w_cnt_inc;
  logic                             w_cfg_run;
  logic                             r_in_group, w_first;
  logic [c_G*c_G-1:0]               r_rep, w_in_rep, w_rep;
  logic [c_G-1:0]                   r_zero, w_in_zero, w_zero;
  logic [c_G-1:0]                   r_need, w_in_need, w_need;
  logic [c_G-1:0]                   r_pending, w_pend, w_cur, w_pend_after;
  logic [c_G-1:0]                   w_col_mask;
  logic [DATA_WIDTH-1:0]            w_value;
  logic [c_G-1:0][DATA_WIDTH-1:0]   r_row_val, w_row_val, w_group;
  logic                             w_last, w_avail, w_accept, w_push, w_pop;
  logic [c_OW-1:0]                  r_mem [OUT_FIFO_DEPTH];
  logic [c_AW-1:0]                  r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]                  r_count;
  logic                             w_empty, w_full;

  // A size of zero or beyond the hardware maximum selects the full group.
  assign w_size_cfg  = (cfg_group_size == '0 || cfg_group_size > c_SW'(c_G)) ? c_SW'(c_G)
                                                                           : cfg_group_size;
  assign w_total_cfg = 32'(num_iters) * 32'(num_reads_per_iter);
  assign w_cfg_run   = (num_iters != '0) && (num_reads_per_iter != '0);

  assign w_value   = bus.data_in[DATA_WIDTH-1:0];
  assign w_in_rep  = bus.data_in[c_REP_LSB +: c_G*c_G];
  assign w_in_zero = bus.data_in[c_ZERO_LSB +: c_G] & w_col_mask;

  for (genvar j = 0; j < c_G; j++) begin : g_col
    assign w_col_mask[j] = (c_SW'(j) < r_size);
  end

  for (genvar r = 0; r < c_G; r++) begin : g_row
    assign w_in_need[r] = w_col_mask[r] & (|(w_in_rep[r*c_G +: c_G] & w_col_mask)) & ~w_in_zero[r];
  end

  // Metadata is live on the first beat only; later beats reuse the latched copy.
  assign w_first      = ~r_in_group;
  assign w_rep        = w_first ? w_in_rep  : r_rep;
  assign w_zero       = w_first ? w_in_zero : r_zero;
  assign w_need       = w_first ? w_in_need : r_need;
  assign w_pend       = w_first ? w_in_need : r_pending;
  assign w_cur        = w_pend & (~w_pend + c_G'(1));
  assign w_pend_after = w_pend & ~w_cur;
  assign w_last       = (w_pend_after == '0);

  always_comb begin
    w_row_val = r_row_val;
    for (int r = 0; r < c_G; r++) begin
      if (w_cur[r]) w_row_val[r] = w_value;
    end
    w_group = '0;
    for (int j = 0; j < c_G; j++) begin
      // Descending scan so the lowest matching needed row wins.
      for (int r = c_G - 1; r >= 0; r--) begin
        if (w_need[r] && w_rep[r*c_G + j]) w_group[j] = w_row_val[r];
      end
      if (w_zero[j] || !w_col_mask[j]) w_group[j] = '0;
    end
  end

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_CW'(OUT_FIFO_DEPTH));
  assign w_avail   = (r_state == S_RUN) && !w_full;
  assign w_accept  = bus.valid_in && w_avail && !configure;
  assign w_push    = w_accept && w_last;
  assign w_pop     = !w_empty && bus.avail_in && !configure;
  assign w_cnt_inc = r_group_cnt + 32'd1;

  assign bus.avail_out = w_avail;
  assign bus.valid_out = !w_empty;
  assign bus.data_out  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign done          = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (configure) begin
      w_state_nxt = w_cfg_run ? S_RUN : S_DONE;
    end else begin
      case (r_state)
        S_RUN:   if (w_push && w_cnt_inc == r_total) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_size      <= '0;
      r_total     <= '0;
      r_group_cnt <= '0;
      r_in_group  <= 1'b0;
      r_rep       <= '0;
      r_zero      <= '0;
      r_need      <= '0;
      r_pending   <= '0;
      r_row_val   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else if (configure) begin
      r_size      <= w_size_cfg;
      r_total     <= w_total_cfg;
      r_group_cnt <= '0;
      r_in_group  <= 1'b0;
      r_pending   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_accept) begin
        r_row_val  <= w_row_val;
        r_in_group <= !w_last;
        r_pending  <= w_last ? '0 : w_pend_after;
        if (w_first) begin
          r_rep  <= w_in_rep;
          r_zero <= w_in_zero;
          r_need <= w_in_need;
        end
      end
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + c_AW'(1);
        r_group_cnt <= w_cnt_inc;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_group;
  end

`ifdef AGRUPATE_CFG_STATS_EN
  logic [31:0] r_stat_groups, r_stat_zero, w_zero_cnt;
  logic [32:0] w_zero_sum;

  always_comb begin
    w_zero_cnt = '0;
    for (int j = 0; j < c_G; j++) w_zero_cnt = w_zero_cnt + 32'(w_zero[j]);
  end
  assign w_zero_sum = {1'b0, r_stat_zero} + {1'b0, w_zero_cnt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_groups <= '0;
      r_stat_zero   <= '0;
    end else if (configure) begin
      r_stat_groups <= '0;
      r_stat_zero   <= '0;
    end else if (w_push) begin
      if (r_stat_groups != '1) r_stat_groups <= r_stat_groups + 32'd1;
      r_stat_zero <= w_zero_sum[32] ? '1 : w_zero_sum[31:0];
    end
  end

  assign stat_groups     = r_stat_groups;
  assign stat_zero_slots = r_stat_zero;
`endif
endmodule
`default_nettype wire

// File: tb/tb_agrupate_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_agrupate_cfg : directed self-checking bench for agrupate_cfg. Rev 1.0  |
// +--------------------------------------------------------------------------+
module tb_agrupate_cfg;
  logic        clk;
  logic        rst;
  logic        configure;
  logic [15:0] num_iters;
  logic [15:0] num_reads_per_iter;
  logic [2:0]  cfg_group_size;
  logic        done;
  int          n_pass;
  int          n_total;
`ifdef AGRUPATE_CFG_STATS_EN
  logic [31:0] stat_groups;
  logic [31:0] stat_zero_slots;
`endif

  agrupate_cfg_if #(.DATA_WIDTH(16), .MAX_GROUP_SIZE(4)) bus ();

  agrupate_cfg #(
    .DATA_WIDTH(16), .MAX_GROUP_SIZE(4), .LOG_MAX_ITERS(16),
    .LOG_MAX_READS_PER_ITER(16), .OUT_FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .configure(configure),
    .num_iters(num_iters),
    .num_reads_per_iter(num_reads_per_iter),
    .cfg_group_size(cfg_group_size),
    .bus(bus),
    .done(done)
`ifdef AGRUPATE_CFG_STATS_EN
    ,
    .stat_groups(stat_groups),
    .stat_zero_slots(stat_zero_slots)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required finish");
    $fatal(1);
  end

  function automatic logic [35:0] beat(input logic [15:0] v, input logic [15:0] rep,
                                       input logic [3:0] zero);
    return {zero, rep, v};
  endfunction

  function automatic logic [63:0] rep4(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_cfg(input logic [15:0] it, input logic [15:0] rd, input logic [2:0] sz);
    num_iters          = it;
    num_reads_per_iter = rd;
    cfg_group_size     = sz;
    configure          = 1'b1;
    tick();
    configure          = 1'b0;
  endtask

  task automatic send(input logic [35:0] d);
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    tick();
    bus.valid_in = 1'b0;
  endtask

  initial begin
    int waited;
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    configure = 1'b0;
    num_iters = '0;
    num_reads_per_iter = '0;
    cfg_group_size = '0;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.avail_in = 1'b0;
    repeat (3) tick();
    check("rst_avail_out", bus.avail_out, 0);
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    tick();

    // Three needed rows (row 0 zeroed), metadata on later beats is junk.
    do_cfg(16'd1, 16'd100, 3'd4);
    check("run_avail_out", bus.avail_out, 1);
    check("run_done", done, 0);
    send(beat(16'd1, 16'h8421, 4'b0001));
    send(beat(16'd3, 16'h0000, 4'b1111));
    check("t1_no_early_valid", bus.valid_out, 0);
    send(beat(16'd4, 16'hFFFF, 4'b0000));
    check("t1_valid", bus.valid_out, 1);
    check("t1_data", bus.data_out, 64'h0004_0003_0001_0000);
    tick();
    check("t1_hold", bus.data_out, 64'h0004_0003_0001_0000);
    bus.avail_in = 1'b1;
    tick();
    bus.avail_in = 1'b0;
    check("t1_popped", bus.valid_out, 0);

    // Row 0 broadcasts to all slots; one beat completes the group.
    send(beat(16'd5, 16'h000F, 4'b0000));
    check("t2_valid", bus.valid_out, 1);
    check("t2_data", bus.data_out, 64'h0005_0005_0005_0005);
    bus.avail_in = 1'b1;
    tick();
    bus.avail_in = 1'b0;
    check("t2_popped", bus.valid_out, 0);

    // Group size 2: rows/slots 2,3 ignored.
    do_cfg(16'd1, 16'd100, 3'd2);
    send(beat(16'd7, 16'h8421, 4'b0000));
    check("t3_after_beat1", bus.valid_out, 0);
    send(beat(16'd8, 16'h8421, 4'b0000));
    check("t3_data", bus.data_out, 64'h0000_0000_0008_0007);
    bus.avail_in = 1'b1;
    tick();
    bus.avail_in = 1'b0;

    // Backpressure: fill the FIFO, then drain in order.
    do_cfg(16'd1, 16'd100, 3'd0);
    for (int i = 1; i <= 4; i++) begin
      send(beat(16'h0010 + 16'(i), 16'h000F, 4'b0000));
      check($sformatf("t4_avail_after_push%0d", i), bus.avail_out, (i < 4) ? 1 : 0);
    end
    check("t4_head0", bus.data_out, rep4(16'h0011));
    bus.avail_in = 1'b1;
    tick();
    check("t4_avail_reassert", bus.avail_out, 1);
    check("t4_head1", bus.data_out, rep4(16'h0012));
    tick();
    check("t4_head2", bus.data_out, rep4(16'h0013));
    tick();
    check("t4_head3", bus.data_out, rep4(16'h0014));
    tick();
    check("t4_empty", bus.valid_out, 0);

    // 2 x 4 groups with avail_in high, then drain to DONE.
    do_cfg(16'd2, 16'd4, 3'd0);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.data_in = beat(16'h0020 + 16'(i), 16'h000F, 4'b0000);
      tick();
      check($sformatf("t5_group%0d", i), bus.data_out, rep4(16'h0020 + 16'(i)));
    end
    bus.valid_in = 1'b0;
    check("t5_avail_drop", bus.avail_out, 0);
    check("t5_not_done_yet", done, 0);
    waited = 0;
    while (!done && waited < 20) begin
      tick();
      waited++;
    end
    check("t5_done", done, 1);
    check("t5_fifo_empty", bus.valid_out, 0);
    do_cfg(16'd0, 16'd4, 3'd0);
    check("t5_zero_iters_done", done, 1);
    check("t5_zero_iters_avail", bus.avail_out, 0);
    bus.avail_in = 1'b0;

    // Abort by configure mid-group with two FIFO entries; configure beats valid_in.
    do_cfg(16'd1, 16'd100, 3'd4);
    send(beat(16'h0031, 16'h000F, 4'b0000));
    send(beat(16'h0032, 16'h000F, 4'b0000));
    send(beat(16'd1, 16'h8421, 4'b0001));
    send(beat(16'd3, 16'h8421, 4'b0001));
    bus.valid_in = 1'b1;
    bus.data_in  = beat(16'd4, 16'h8421, 4'b0001);
    do_cfg(16'd1, 16'd100, 3'd4);
    bus.valid_in = 1'b0;
    check("t6_cfg_flush_valid", bus.valid_out, 0);
    check("t6_cfg_avail", bus.avail_out, 1);
    send(beat(16'd9, 16'h000F, 4'b0000));
    check("t6_cfg_clean_group", bus.data_out, rep4(16'd9));
    bus.avail_in = 1'b1;
    tick();
    bus.avail_in = 1'b0;

    // Same abort via reset.
    send(beat(16'h0041, 16'h000F, 4'b0000));
    send(beat(16'h0042, 16'h000F, 4'b0000));
    send(beat(16'd1, 16'h8421, 4'b0001));
    send(beat(16'd3, 16'h8421, 4'b0001));
    rst = 1'b0;
    tick();
    check("t6_rst_valid", bus.valid_out, 0);
    check("t6_rst_avail", bus.avail_out, 0);
    check("t6_rst_data", bus.data_out, 0);
    rst = 1'b1;
    tick();
    do_cfg(16'd1, 16'd100, 3'd4);
    send(beat(16'h000A, 16'h000F, 4'b0000));
    check("t6_rst_clean_group", bus.data_out, rep4(16'h000A));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
